// File: rtl/mod_counter_pkg.sv
// ---------------------------------------------------------------------------
// mod_counter_pkg
// Shared encodings for the modulus counter and its prescaler.
//   DIR_UP / DIR_DOWN   : meaning of the i_dir input
//   POL_WRAP / POL_SAT  : meaning of the i_sat input (boundary policy)
// ---------------------------------------------------------------------------
package mod_counter_pkg;

  // Count direction selected by i_dir
  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  // Boundary policy selected by i_sat
  localparam logic POL_WRAP = 1'b0;
  localparam logic POL_SAT  = 1'b1;

endpackage : mod_counter_pkg

// File: rtl/mod_counter_step_prescaler.sv
// ---------------------------------------------------------------------------
// step_prescaler
// Integer prescaler that turns enabled cycles into step events.
// A tick is produced on every (div+1)-th enabled cycle.
// Ports:
//   i_clk   : clock, rising edge
//   i_rst   : synchronous active-high reset
//   i_en    : enable; the prescaler only advances while high
//   i_clr   : synchronous restart of the prescaler (driven by the counter load)
//   i_div   : divide value; tick every i_div+1 enabled cycles
//   o_tick  : combinational; high when this edge is a step event
// ---------------------------------------------------------------------------
module step_prescaler
  import mod_counter_pkg::*;
#(
  parameter int DIV_W = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic             i_clr,
  input  logic [DIV_W-1:0] i_div,
  output logic             o_tick
);

  logic [DIV_W-1:0] r_phase;
  logic             w_tick;

  // The >= compare (rather than ==) means that lowering i_div below the
  // current phase fires an event on the next enabled edge instead of
  // running the phase all the way around the register.
  always_comb begin
    w_tick = i_en && (r_phase >= i_div);
  end

  assign o_tick = w_tick;

  // Phase register: restarts on reset or load, holds while disabled,
  // returns to zero on each event. r_phase < i_div whenever it increments,
  // so the +1 never overflows.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_phase <= '0;
    end else if (i_en) begin
      if (w_tick) begin
        r_phase <= '0;
      end else begin
        r_phase <= r_phase + 1'b1;
      end
    end
  end

endmodule : step_prescaler

// File: rtl/mod_counter.sv
// ---------------------------------------------------------------------------
// mod_counter
// Parametrised up/down modulus counter with load, wrap/saturate policy,
// step prescaler, terminal-count pulse and sticky overflow/underflow flags.
// Ports:
//   i_clk        : clock, rising edge
//   i_rst        : synchronous active-high reset (overrides everything)
//   i_en         : count enable, gates the prescaler
//   i_load       : overwrite request (beats a step event)
//   i_load_data  : value to load, clamped to i_limit
//   i_dir        : 0 = up, 1 = down
//   i_sat        : 0 = wrap at boundary, 1 = saturate at boundary
//   i_limit      : maximum count value (modulus - 1)
//   i_div        : step event every i_div+1 enabled cycles
//   i_flag_clr   : clears o_ovf / o_udf (a same-edge set wins)
//   o_count      : current count
//   o_step       : one-cycle pulse, a step event was processed
//   o_tc         : one-cycle pulse, that step event hit a boundary
//   o_ovf        : sticky, an up-step happened at or above i_limit
//   o_udf        : sticky, a down-step happened at zero
// ---------------------------------------------------------------------------
module mod_counter
  import mod_counter_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIV_W = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_data,
  input  logic             i_dir,
  input  logic             i_sat,
  input  logic [WIDTH-1:0] i_limit,
  input  logic [DIV_W-1:0] i_div,
  input  logic             i_flag_clr,
  output logic [WIDTH-1:0] o_count,
  output logic             o_step,
  output logic             o_tc,
  output logic             o_ovf,
  output logic             o_udf
);

  logic [WIDTH-1:0] r_count;
  logic             r_step;
  logic             r_tc;
  logic             r_ovf;
  logic             r_udf;

  logic             w_tick;
  logic [WIDTH-1:0] w_nextCount;
  logic [WIDTH-1:0] w_downVal;
  logic [WIDTH-1:0] w_loadVal;
  logic             w_boundary;
  logic             w_ovfSet;
  logic             w_udfSet;

  // The prescaler restarts whenever a load is accepted, so the first
  // step after a load always waits a full div+1 enabled cycles.
  step_prescaler #(
    .DIV_W (DIV_W)
  ) u_prescaler (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_en   (i_en),
    .i_clr  (i_load),
    .i_div  (i_div),
    .o_tick (w_tick)
  );

  // Loaded values never exceed the modulus.
  always_comb begin
    w_loadVal = (i_load_data > i_limit) ? i_limit : i_load_data;
  end

  // Next count for a step event, plus which boundary (if any) it hit.
  // A count above i_limit only appears after i_limit was lowered at run
  // time: going up it is treated as a boundary, going down the result is
  // pulled back inside the modulus.
  always_comb begin
    w_nextCount = r_count;
    w_downVal   = r_count - 1'b1;
    w_boundary  = 1'b0;
    w_ovfSet    = 1'b0;
    w_udfSet    = 1'b0;
    if (i_dir == DIR_UP) begin
      if (r_count < i_limit) begin
        w_nextCount = r_count + 1'b1;
      end else begin
        w_boundary  = 1'b1;
        w_ovfSet    = 1'b1;
        w_nextCount = (i_sat == POL_SAT) ? i_limit : '0;
      end
    end else begin
      if (r_count != '0) begin
        w_nextCount = (w_downVal > i_limit) ? i_limit : w_downVal;
      end else begin
        w_boundary  = 1'b1;
        w_udfSet    = 1'b1;
        w_nextCount = (i_sat == POL_SAT) ? '0 : i_limit;
      end
    end
  end

  // Count, pulses and flags. Priority is reset, then load, then a step
  // event. Flags are cleared by i_flag_clr unless the same edge sets them.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count <= '0;
      r_step  <= 1'b0;
      r_tc    <= 1'b0;
      r_ovf   <= 1'b0;
      r_udf   <= 1'b0;
    end else if (i_load) begin
      r_count <= w_loadVal;
      r_step  <= 1'b0;
      r_tc    <= 1'b0;
      r_ovf   <= r_ovf & ~i_flag_clr;
      r_udf   <= r_udf & ~i_flag_clr;
    end else begin
      if (w_tick) begin
        r_count <= w_nextCount;
      end
      r_step <= w_tick;
      r_tc   <= w_tick & w_boundary;
      r_ovf  <= (w_tick & w_ovfSet) | (r_ovf & ~i_flag_clr);
      r_udf  <= (w_tick & w_udfSet) | (r_udf & ~i_flag_clr);
    end
  end

  assign o_count = r_count;
  assign o_step  = r_step;
  assign o_tc    = r_tc;
  assign o_ovf   = r_ovf;
  assign o_udf   = r_udf;

endmodule : mod_counter

// File: tb/tb_mod_counter.sv
// ---------------------------------------------------------------------------
// tb_mod_counter
// Self-checking bench for mod_counter: a behavioural integer model updated
// on every rising edge, compared against the DUT on every falling edge,
// plus literal expectations at the end of each directed scenario and a
// randomized run.
// ---------------------------------------------------------------------------
module tb_mod_counter;

  localparam int WIDTH = 8;
  localparam int DIV_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic             load;
  logic [WIDTH-1:0] loadData;
  logic             dir;
  logic             sat;
  logic [WIDTH-1:0] limit;
  logic [DIV_W-1:0] div;
  logic             flagClr;
  logic [WIDTH-1:0] count;
  logic             step;
  logic             tc;
  logic             ovf;
  logic             udf;

  int total = 0;
  int bad   = 0;
  bit checkEn = 1'b0;

  // Model state, plain integers
  int mCount = 0;
  int mPre   = 0;
  int mStep  = 0;
  int mTc    = 0;
  int mOvf   = 0;
  int mUdf   = 0;

  mod_counter #(
    .WIDTH (WIDTH),
    .DIV_W (DIV_W)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_en        (en),
    .i_load      (load),
    .i_load_data (loadData),
    .i_dir       (dir),
    .i_sat       (sat),
    .i_limit     (limit),
    .i_div       (div),
    .i_flag_clr  (flagClr),
    .o_count     (count),
    .o_step      (step),
    .o_tc        (tc),
    .o_ovf       (ovf),
    .o_udf       (udf)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d want %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Behavioural model: counter value as an integer in [0, limit]
  always @(posedge clk) begin
    int lim;
    int ev;
    int setO;
    int setU;
    lim  = int'(limit);
    setO = 0;
    setU = 0;
    if (rst) begin
      mCount = 0; mPre = 0; mStep = 0; mTc = 0; mOvf = 0; mUdf = 0;
    end else if (load) begin
      mCount = (int'(loadData) > lim) ? lim : int'(loadData);
      mPre   = 0;
      mStep  = 0;
      mTc    = 0;
      if (flagClr) begin
        mOvf = 0;
        mUdf = 0;
      end
    end else begin
      ev = (en && mPre >= int'(div)) ? 1 : 0;
      if (en) mPre = ev ? 0 : mPre + 1;
      mStep = ev;
      mTc   = 0;
      if (ev) begin
        if (dir == 1'b0) begin
          if (mCount < lim) mCount = mCount + 1;
          else begin
            mTc = 1; setO = 1;
            mCount = sat ? lim : 0;
          end
        end else begin
          if (mCount > 0) mCount = (mCount - 1 > lim) ? lim : mCount - 1;
          else begin
            mTc = 1; setU = 1;
            mCount = sat ? 0 : lim;
          end
        end
      end
      mOvf = (setO != 0 || (mOvf != 0 && !flagClr)) ? 1 : 0;
      mUdf = (setU != 0 || (mUdf != 0 && !flagClr)) ? 1 : 0;
    end
  end

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("model.count", int'(count), mCount);
      checkOutput("model.step",  int'(step),  mStep);
      checkOutput("model.tc",    int'(tc),    mTc);
      checkOutput("model.ovf",   int'(ovf),   mOvf);
      checkOutput("model.udf",   int'(udf),   mUdf);
    end
  end

  // Drive one cycle of inputs, then wait until just after the next edge
  task automatic applyStimulus(input logic r, input logic e, input logic l,
                               input int ld, input logic d, input logic s,
                               input int lim, input int dv, input logic fc);
    rst      = r;
    en       = e;
    load     = l;
    loadData = WIDTH'(ld);
    dir      = d;
    sat      = s;
    limit    = WIDTH'(lim);
    div      = DIV_W'(dv);
    flagClr  = fc;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; load = 1'b0; loadData = '0; dir = 1'b0;
    sat = 1'b0; limit = 8'd255; div = '0; flagClr = 1'b0;

    // Reset
    applyStimulus(1, 0, 0, 0, 0, 0, 255, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 255, 0, 0);
    checkEn = 1'b1;
    checkOutput("reset.count", int'(count), 0);
    checkOutput("reset.ovf",   int'(ovf),   0);
    checkOutput("reset.step",  int'(step),  0);

    // Full up-count with wrap
    for (int i = 0; i < 255; i++) applyStimulus(0, 1, 0, 0, 0, 0, 255, 0, 0);
    checkOutput("up.count255", int'(count), 255);
    checkOutput("up.tcLow",    int'(tc),    0);
    applyStimulus(0, 1, 0, 0, 0, 0, 255, 0, 0);
    checkOutput("wrap.count", int'(count), 0);
    checkOutput("wrap.ovf",   int'(ovf),   1);
    checkOutput("wrap.tc",    int'(tc),    1);
    checkOutput("wrap.step",  int'(step),  1);
    applyStimulus(0, 1, 0, 0, 0, 0, 255, 0, 0);
    checkOutput("wrap.tcOnce", int'(tc),    0);
    checkOutput("wrap.next",   int'(count), 1);

    // Prescaler div=3 with an enable gap
    applyStimulus(0, 0, 1, 0, 0, 0, 255, 3, 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, 0, 0, 0, 0, 255, 3, 0);
    checkOutput("div3.before", int'(count), 0);
    applyStimulus(0, 1, 0, 0, 0, 0, 255, 3, 0);
    checkOutput("div3.first", int'(count), 1);
    applyStimulus(0, 1, 0, 0, 0, 0, 255, 3, 0);
    applyStimulus(0, 1, 0, 0, 0, 0, 255, 3, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 255, 3, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 255, 3, 0);
    applyStimulus(0, 1, 0, 0, 0, 0, 255, 3, 0);
    checkOutput("div3.held", int'(count), 1);
    applyStimulus(0, 1, 0, 0, 0, 0, 255, 3, 0);
    checkOutput("div3.delayed", int'(count), 2);

    // Saturating down-count into zero
    applyStimulus(0, 0, 1, 2, 1, 1, 255, 0, 0);
    checkOutput("down.load", int'(count), 2);
    applyStimulus(0, 1, 0, 0, 1, 1, 255, 0, 0);
    applyStimulus(0, 1, 0, 0, 1, 1, 255, 0, 0);
    checkOutput("down.zero", int'(count), 0);
    checkOutput("down.udfLow", int'(udf), 0);
    applyStimulus(0, 1, 0, 0, 1, 1, 255, 0, 0);
    checkOutput("down.satCount", int'(count), 0);
    checkOutput("down.udf",      int'(udf),   1);
    checkOutput("down.tc",       int'(tc),    1);
    checkOutput("down.step",     int'(step),  1);
    applyStimulus(0, 1, 0, 0, 1, 1, 255, 0, 0);
    checkOutput("down.stays", int'(count), 0);

    // Clamped load while the prescaler is at div
    applyStimulus(0, 0, 1, 0, 0, 0, 100, 3, 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, 0, 0, 0, 0, 100, 3, 0);
    applyStimulus(0, 1, 1, 200, 0, 0, 100, 3, 0);
    checkOutput("clamp.count", int'(count), 100);
    checkOutput("clamp.step",  int'(step),  0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, 0, 0, 0, 0, 100, 3, 0);
    checkOutput("clamp.noStep", int'(step), 0);
    applyStimulus(0, 1, 0, 0, 0, 0, 100, 3, 0);
    checkOutput("clamp.stepBack", int'(step),  1);
    checkOutput("clamp.wrapped",  int'(count), 0);

    // Flag clear colliding with a set
    applyStimulus(0, 0, 1, 3, 0, 0, 3, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 0, 3, 0, 1);
    checkOutput("clr.setWins", int'(ovf), 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 3, 0, 1);
    checkOutput("clr.cleared", int'(ovf), 0);

    // Reset beats load
    applyStimulus(0, 0, 1, 57, 0, 0, 255, 2, 0);
    applyStimulus(1, 1, 1, 9, 0, 0, 255, 2, 0);
    checkOutput("rstLoad.count", int'(count), 0);
    checkOutput("rstLoad.udf",   int'(udf),   0);
    applyStimulus(0, 1, 0, 0, 0, 0, 255, 2, 0);
    applyStimulus(0, 1, 0, 0, 0, 0, 255, 2, 0);
    checkOutput("rstLoad.preZero", int'(step), 0);
    applyStimulus(0, 1, 0, 0, 0, 0, 255, 2, 0);
    checkOutput("rstLoad.firstStep", int'(count), 1);

    // Randomized run, including run-time limit and div changes
    begin
      int lim = 20;
      int dv  = 0;
      for (int i = 0; i < 3000; i++) begin
        if ($urandom_range(31) == 0) lim = ($urandom_range(3) == 0) ? $urandom_range(3) : $urandom_range(255);
        if ($urandom_range(15) == 0) dv = $urandom_range(3);
        applyStimulus($urandom_range(63) == 0, $urandom_range(3) != 0,
                      $urandom_range(15) == 0, $urandom_range(255),
                      1'($urandom_range(1)), 1'($urandom_range(1)),
                      lim, dv, $urandom_range(15) == 0);
      end
    end

    @(negedge clk);
    checkEn = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_mod_counter
